// File: rtl/sfr_mt_if.sv
// MemSplit32: single-beat register bus with split request/response phases.
interface MemSplit32;
    logic        req;
    logic        ack;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;
    modport Master (output req, we, addr, wdata, input ack, rdata, resp);
    modport Slave  (input req, we, addr, wdata, output ack, rdata, resp);
endinterface

// File: rtl/sfr_mt.sv
// sfr_mt: tile SFR block with ID/CTRL/CORENUM/SGI registers and TIMER_NUM prescaled timer channels.
module sfr_mt #(
    parameter logic [31:0] corenum          = 32'd0,
    parameter bit          SW_RESET_DEFAULT = 1'b0,
    parameter int          IRQ_NUM_POW      = 4,
    parameter int          TIMER_NUM        = 4,
    parameter int          PRESCALER_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    MemSplit32.Slave               host,
    output logic                   sw_reset_o,
    output logic                   irq_timer_o,
    output logic [TIMER_NUM-1:0]   irq_status_bo,
    output logic                   sgi_req_o,
    output logic [IRQ_NUM_POW-1:0] sgi_code_bo
);
    localparam int T  = TIMER_NUM;
    localparam int PW = PRESCALER_WIDTH;

    logic [7:0] a;
    logic       wr, rd, unused_addr;
    assign a           = {host.addr[7:2], 2'b00};
    assign wr          = host.req & host.we;
    assign rd          = host.req & ~host.we;
    assign unused_addr = ^{host.addr[31:8], host.addr[1:0]};
    assign host.ack    = host.req;

    logic                   ctrl_sw_q, ctrl_sw_d, sw_reset_q, irq_q, resp_q;
    logic                   sgi_req_q, sgi_req_d;
    logic [IRQ_NUM_POW-1:0] sgi_code_q, sgi_code_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [T-1:0]           status_q, status_d, mask_q, mask_d;
    logic [T-1:0]           en_q, en_d, rl_q, rl_d, tick, expire;
    logic [31:0]            period_q [T], period_d [T], value_q [T], value_d [T];
    logic [PW-1:0]          pre_q [T], pre_d [T], pcnt_q [T], pcnt_d [T];

    always_comb begin
        ctrl_sw_d  = (wr && a == 8'h04) ? host.wdata[0] : ctrl_sw_q;
        sgi_req_d  = wr && a == 8'h0C;
        sgi_code_d = sgi_req_d ? host.wdata[IRQ_NUM_POW-1:0] : sgi_code_q;
        mask_d     = (wr && a == 8'h14) ? host.wdata[T-1:0] : mask_q;
        status_d   = status_q & ~((wr && a == 8'h10) ? host.wdata[T-1:0] : '0);
        rdata_d    = !rd          ? 32'd0 :
                     a == 8'h00   ? 32'h5F50_0002 :
                     a == 8'h04   ? {31'd0, ctrl_sw_q} :
                     a == 8'h08   ? corenum :
                     a == 8'h10   ? 32'(status_q) :
                     a == 8'h14   ? 32'(mask_q) : 32'd0;
        tick       = '0;
        expire     = '0;
        en_d       = en_q;
        rl_d       = rl_q;
        for (int i = 0; i < T; i++) begin
            tick[i]     = en_q[i] && pcnt_q[i] == pre_q[i];
            expire[i]   = tick[i] && value_q[i] == period_q[i];
            pcnt_d[i]   = !en_q[i] ? pcnt_q[i] : tick[i] ? '0 : pcnt_q[i] + 1'b1;
            value_d[i]  = !tick[i] ? value_q[i] : expire[i] ? 32'd0 : value_q[i] + 32'd1;
            en_d[i]     = expire[i] ? rl_q[i] : en_q[i];
            period_d[i] = (wr && a == {4'(i + 2), 4'h4}) ? host.wdata : period_q[i];
            pre_d[i]    = (wr && a == {4'(i + 2), 4'h8}) ? host.wdata[PW-1:0] : pre_q[i];
            // A TCTRL write restarts the channel and swallows a coincident expiry.
            if (wr && a == {4'(i + 2), 4'h0}) begin
                value_d[i] = 32'd0;
                pcnt_d[i]  = '0;
                en_d[i]    = host.wdata[0];
                rl_d[i]    = host.wdata[1];
            end else if (expire[i])
                status_d[i] = 1'b1;
            if (rd && a[7:4] == 4'(i + 2))
                rdata_d = a[3:2] == 2'd0 ? {30'd0, rl_q[i], en_q[i]} :
                          a[3:2] == 2'd1 ? period_q[i] :
                          a[3:2] == 2'd2 ? 32'(pre_q[i]) : value_q[i];
        end
        if (sw_reset_q) begin
            status_d = '0;
            mask_d   = '0;
            en_d     = '0;
            rl_d     = '0;
            for (int i = 0; i < T; i++) begin
                period_d[i] = 32'd0;
                value_d[i]  = 32'd0;
                pre_d[i]    = '0;
                pcnt_d[i]   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_sw_q  <= SW_RESET_DEFAULT;
            sw_reset_q <= 1'b1;
            irq_q      <= 1'b0;
            resp_q     <= 1'b0;
            rdata_q    <= 32'd0;
            sgi_req_q  <= 1'b0;
            sgi_code_q <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            en_q       <= '0;
            rl_q       <= '0;
            for (int i = 0; i < T; i++) begin
                period_q[i] <= 32'd0;
                value_q[i]  <= 32'd0;
                pre_q[i]    <= '0;
                pcnt_q[i]   <= '0;
            end
        end else begin
            ctrl_sw_q  <= ctrl_sw_d;
            sw_reset_q <= ctrl_sw_q;
            irq_q      <= |(status_q & mask_q);
            resp_q     <= rd;
            rdata_q    <= rdata_d;
            sgi_req_q  <= sgi_req_d;
            sgi_code_q <= sgi_code_d;
            status_q   <= status_d;
            mask_q     <= mask_d;
            en_q       <= en_d;
            rl_q       <= rl_d;
            for (int i = 0; i < T; i++) begin
                period_q[i] <= period_d[i];
                value_q[i]  <= value_d[i];
                pre_q[i]    <= pre_d[i];
                pcnt_q[i]   <= pcnt_d[i];
            end
        end
    end

    assign host.resp     = resp_q;
    assign host.rdata    = rdata_q;
    assign sw_reset_o    = sw_reset_q;
    assign irq_timer_o   = irq_q;
    assign irq_status_bo = status_q;
    assign sgi_req_o     = sgi_req_q;
    assign sgi_code_bo   = sgi_code_q;
endmodule
